rng_byte_arbiter: RTL and testbench

// - Shares one PRNG word stream (SHAKE256/ChaCha output) among NUM_REQ byte-consuming samplers
//   (berexp, base sampler, sign-bit draw).
// - Unpacks 64-bit words into a byte buffer. Serves one byte per cycle to one requester,

---
 rtl/rng_byte_arbiter_pkg.sv | 9 +
 rtl/rng_byte_fifo.sv | 90 +++++++++
 rtl/rng_byte_arbiter.sv | 93 +++++++++
 tb/tb_rng_byte_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rng_byte_arbiter_pkg.sv
// Shared constants and types for the PRNG byte arbiter slice.
package rng_byte_arbiter_pkg;

  localparam int unsigned RNG_WORD_W    = 64;
  localparam int unsigned RNG_BUF_BYTES = 16;

  typedef logic [7:0] rng_byte_t;

endpackage

// File: rtl/rng_byte_fifo.sv
// Circular byte buffer: writes a whole PRNG word per push, reads one byte per pop.
module rng_byte_fifo
  import rng_byte_arbiter_pkg::*;
#(
  parameter int unsigned WORD_W    = RNG_WORD_W,
  parameter int unsigned BUF_BYTES = RNG_BUF_BYTES,
  localparam int unsigned LvlW     = $clog2(BUF_BYTES + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              push_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic              pop_i,
  output rng_byte_t         head_o,
  output logic [LvlW-1:0]   level_o
);

  localparam int unsigned WordBytes = WORD_W / 8;
  localparam int unsigned PtrW      = $clog2(BUF_BYTES);

  rng_byte_t       mem_q [BUF_BYTES];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0] level_q, level_d;
  rng_byte_t       last_q;
  logic [PtrW-1:0] wr_idx [WordBytes];
  logic            pop_ok;

  // Depth need not be a power of two, so wrap by compare-and-subtract.
  function automatic logic [PtrW-1:0] wrap_add(input logic [PtrW-1:0] ptr,
                                               input int unsigned inc);
    logic [PtrW:0] sum;
    sum = {1'b0, ptr} + (PtrW+1)'(inc);
    if (sum >= (PtrW+1)'(BUF_BYTES)) begin
      sum = sum - (PtrW+1)'(BUF_BYTES);
    end
    return sum[PtrW-1:0];
  endfunction

  always_comb begin
    for (int unsigned k = 0; k < WordBytes; k++) begin
      wr_idx[k] = wrap_add(wr_ptr_q, k);
    end
  end

  assign pop_ok = pop_i && (level_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wrap_add(wr_ptr_q, WordBytes);
      if (pop_ok) rd_ptr_d = wrap_add(rd_ptr_q, 1);
      level_d = level_q + (push_i ? LvlW'(WordBytes) : '0) - (pop_ok ? LvlW'(1) : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !clr_i) begin
      for (int unsigned k = 0; k < WordBytes; k++) begin
        mem_q[wr_idx[k]] <= wdata_i[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      last_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      last_q   <= head_o;
    end
  end

  // When empty the head byte is meaningless, so present the last shown value.
  assign head_o  = (level_q != '0) ? mem_q[rd_ptr_q] : last_q;
  assign level_o = level_q;

endmodule

// File: rtl/rng_byte_arbiter.sv
// Shares one PRNG word stream among NUM_REQ byte consumers, one byte per cycle, round-robin.
module rng_byte_arbiter
  import rng_byte_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned WORD_W    = RNG_WORD_W,
  parameter int unsigned BUF_BYTES = RNG_BUF_BYTES,
  localparam int unsigned LvlW     = $clog2(BUF_BYTES + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush_i,
  input  logic               prng_valid_i,
  output logic               prng_ready_o,
  input  logic [WORD_W-1:0]  prng_data_i,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output rng_byte_t          rand_byte_o,
  output logic [LvlW-1:0]    buf_level_o
);

  localparam int unsigned WordBytes = WORD_W / 8;
  localparam int unsigned RrW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [RrW-1:0] rr_ptr_q, rr_ptr_d;
  logic [RrW-1:0] gnt_idx;
  logic [RrW-1:0] cand;
  logic           gnt_any;
  logic           push;

  function automatic logic [RrW-1:0] rr_add(input logic [RrW-1:0] ptr, input int unsigned inc);
    logic [RrW:0] sum;
    sum = {1'b0, ptr} + (RrW+1)'(inc);
    if (sum >= (RrW+1)'(NUM_REQ)) begin
      sum = sum - (RrW+1)'(NUM_REQ);
    end
    return sum[RrW-1:0];
  endfunction

  // First set request at or after rr_ptr, wrapping.
  always_comb begin
    gnt_o   = '0;
    gnt_idx = '0;
    cand    = '0;
    gnt_any = 1'b0;
    if (!flush_i && (buf_level_o != '0)) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        cand = rr_add(rr_ptr_q, k);
        if (!gnt_any && req_i[cand]) begin
          gnt_any = 1'b1;
          gnt_idx = cand;
        end
      end
    end
    if (gnt_any) gnt_o[gnt_idx] = 1'b1;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (flush_i) begin
      rr_ptr_d = '0;
    end else if (gnt_any) begin
      rr_ptr_d = rr_add(gnt_idx, 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Only accept a word when all of its bytes fit; never a partial word.
  assign prng_ready_o = !flush_i && (buf_level_o <= LvlW'(BUF_BYTES - WordBytes));
  assign push         = prng_valid_i && prng_ready_o;

  rng_byte_fifo #(
    .WORD_W   (WORD_W),
    .BUF_BYTES(BUF_BYTES)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (flush_i),
    .push_i (push),
    .wdata_i(prng_data_i),
    .pop_i  (gnt_any),
    .head_o (rand_byte_o),
    .level_o(buf_level_o)
  );

endmodule

// File: tb/tb_rng_byte_arbiter.sv
// Self-checking bench: queue-based model of the byte arbiter plus directed literal checks.
module tb_rng_byte_arbiter;
  import rng_byte_arbiter_pkg::*;

  localparam int N  = 2;
  localparam int WB = 8;
  localparam int BB = 16;
  localparam int LW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          valid = 1'b0;
  logic [63:0]   data = '0;
  logic [N-1:0]  req = '0;
  logic          ready;
  logic [N-1:0]  gnt;
  rng_byte_t     rbyte;
  logic [LW-1:0] level;

  int checks = 0;
  int errors = 0;

  logic [7:0]   mq[$];
  int           rr = 0;
  logic [7:0]   log0[$];
  logic [7:0]   log1[$];
  logic [N-1:0] ghist[$];
  int           acc_words = 0;

  rng_byte_arbiter #(
    .NUM_REQ  (N),
    .WORD_W   (64),
    .BUF_BYTES(BB)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush),
    .prng_valid_i(valid),
    .prng_ready_o(ready),
    .prng_data_i (data),
    .req_i       (req),
    .gnt_o       (gnt),
    .rand_byte_o (rbyte),
    .buf_level_o (level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a byte queue and a round-robin pointer, evaluated mid-cycle.
  always @(negedge clk) begin : model
    int           gi;
    int           idx;
    logic [N-1:0] eg;
    logic         er;
    if (!rst_n) begin
      mq.delete();
      rr = 0;
    end else begin
      er = !flush && (mq.size() <= BB - WB);
      gi = -1;
      if (!flush && mq.size() != 0) begin
        for (int k = 0; k < N; k++) begin
          idx = (rr + k) % N;
          if (gi < 0 && ((req >> idx) & 1) != 0) gi = idx;
        end
      end
      eg = '0;
      if (gi >= 0) eg = N'(1) << gi;
      check("prng_ready", 64'(ready), 64'(er));
      check("gnt", 64'(gnt), 64'(eg));
      check("buf_level", 64'(level), 64'(mq.size()));
      if (gi >= 0) check("rand_byte", 64'(rbyte), 64'(mq[0]));
      if (gnt != '0) begin
        ghist.push_back(gnt);
        if (gnt[0]) log0.push_back(rbyte);
        if (gnt[1]) log1.push_back(rbyte);
      end
      if (valid && ready) acc_words++;
      if (flush) begin
        mq.delete();
        rr = 0;
      end else begin
        if (gi >= 0) begin
          void'(mq.pop_front());
          rr = (gi + 1) % N;
        end
        if (valid && er) begin
          for (int b = 0; b < WB; b++) mq.push_back(data[8*b +: 8]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  initial begin
    // Reset
    steps(3);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_gnt", 64'(gnt), 64'd0);
    check("reset_level", 64'(level), 64'd0);
    check("reset_ready", 64'(ready), 64'd1);
    check("reset_rand_byte", 64'(rbyte), 64'd0);

    // Byte order: one word, single requester
    step();
    valid = 1'b1;
    data  = 64'h0807060504030201;
    step();
    valid = 1'b0;
    req   = 2'b01;
    log0.delete();
    steps(8);
    @(negedge clk);
    check("order_9th_gnt", 64'(gnt), 64'd0);
    check("order_level", 64'(level), 64'd0);
    step();
    req = 2'b00;
    check("order_count", 64'(log0.size()), 64'd8);
    for (int k = 0; k < 8; k++) check("order_byte", 64'(log0[k]), 64'(k + 1));

    // Fairness: 16 preloaded bytes, both requesting
    flush = 1'b1;
    step();
    flush = 1'b0;
    valid = 1'b1;
    data  = 64'h0706050403020100;
    step();
    data = 64'h0F0E0D0C0B0A0908;
    step();
    valid = 1'b0;
    req   = 2'b11;
    log0.delete();
    log1.delete();
    ghist.delete();
    steps(16);
    req = 2'b00;
    check("fair_cnt0", 64'(log0.size()), 64'd8);
    check("fair_cnt1", 64'(log1.size()), 64'd8);
    for (int k = 0; k < 8; k++) begin
      check("fair_even", 64'(log0[k]), 64'(2 * k));
      check("fair_odd", 64'(log1[k]), 64'(2 * k + 1));
    end
    for (int k = 0; k < 16; k++) check("fair_gnt_seq", 64'(ghist[k]), (k % 2 == 1) ? 64'd2 : 64'd1);

    // Full: continuous valid, no requests
    acc_words = 0;
    valid = 1'b1;
    data  = 64'h1716151413121110;
    step();
    data = 64'h1F1E1D1C1B1A1918;
    steps(3);
    valid = 1'b0;
    @(negedge clk);
    check("full_words", 64'(acc_words), 64'd2);
    check("full_level", 64'(level), 64'd16);
    check("full_ready", 64'(ready), 64'd0);
    step();
    req = 2'b01;
    steps(7);
    req = 2'b00;
    @(negedge clk);
    check("pop7_level", 64'(level), 64'd9);
    check("pop7_ready", 64'(ready), 64'd0);
    step();
    req = 2'b01;
    step();
    req = 2'b00;
    @(negedge clk);
    check("pop8_level", 64'(level), 64'd8);
    check("pop8_ready", 64'(ready), 64'd1);

    // Simultaneous push and pop at level 8
    step();
    log0.delete();
    valid = 1'b1;
    data  = 64'h2F2E2D2C2B2A2928;
    req   = 2'b01;
    step();
    valid = 1'b0;
    req   = 2'b00;
    @(negedge clk);
    check("simul_level", 64'(level), 64'd15);
    step();
    req = 2'b01;
    steps(15);
    req = 2'b00;
    check("simul_count", 64'(log0.size()), 64'd16);
    for (int k = 0; k < 16; k++)
      check("simul_byte", 64'(log0[k]), (k < 8) ? 64'(8'h18 + k) : 64'(8'h20 + k));

    // Flush mid-stream at level 12
    valid = 1'b1;
    data  = 64'h3736353433323130;
    step();
    data = 64'h3F3E3D3C3B3A3938;
    step();
    valid = 1'b0;
    req   = 2'b10;
    steps(4);
    flush = 1'b1;
    @(negedge clk);
    check("flush_level_before", 64'(level), 64'd12);
    check("flush_gnt", 64'(gnt), 64'd0);
    check("flush_ready", 64'(ready), 64'd0);
    step();
    flush = 1'b0;
    log1.delete();
    @(negedge clk);
    check("flush_level_after", 64'(level), 64'd0);
    check("flush_empty_gnt", 64'(gnt), 64'd0);
    step();
    valid = 1'b1;
    data  = 64'h4746454443424140;
    step();
    valid = 1'b0;
    step();
    check("flush_next_count", 64'(log1.size() >= 1), 64'd1);
    check("flush_next_byte", 64'(log1[0]), 64'h40);

    // Reset mid-stream with a request pending
    rst_n = 1'b0;
    steps(2);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_level", 64'(level), 64'd0);
    check("rst_mid_gnt", 64'(gnt), 64'd0);
    check("rst_mid_ready", 64'(ready), 64'd1);
    step();
    req = 2'b00;
    steps(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
